ascon_seq_ctrl: RTL and testbench
=================================

// Module: ascon_seq_ctrl
// PURPOSE
// - Initiator side of the permutation start/end handshake: drives perm_start_o, waits for perm_end_i.
// - Sequences one ASCON-128 encryption: init (pa), AD blocks (pb), data blocks (pb), final (pa), tag.
// - Pulls 64-bit blocks from the data source via valid/ready.
// - Emits key-XOR and domain-separation strobes to the state datapath.
// - Sits between the top-level command interface and the permutation core.
// PARAMETERS
// MAX_BLOCKS   16  max AD blocks and max data blocks per operation; CW = $clog2(MAX_BLOCKS+1)
// PA_ROUNDS    12  rounds requested for init and final
// PB_ROUNDS     6  rounds requested for AD and intermediate data blocks
// TIMEOUT_CYC  64  watchdog limit in cycles (used only with ASCON_SEQ_TIMEOUT_EN)
// PORTS
// clock_i        in   1   single clock, rising edge
// reset_i        in   1   synchronous, active-high reset
// start_i        in   1   begin operation; sampled only in IDLE
// nb_ad_i        in   CW  AD block count, 0 allowed; sampled with start_i
// nb_data_i      in   CW  data block count, 0 allowed; sampled with start_i
// blk_valid_i    in   1   source presents next block
// blk_ready_o    out  1   block consumed when blk_valid_i & blk_ready_o
// perm_start_o   out  1   one-cycle pulse launching the permutation
// perm_rounds_o  out  4   round count, valid while perm_start_o=1 (else 0)
// perm_end_i     in   1   one-cycle completion pulse from the permutation
// xor_key_o      out  1   one-cycle strobe: XOR key into state
// xor_dom_o      out  1   one-cycle strobe: XOR domain-separation bit
// phase_o        out  4   current FSM state encoding (debug)
// busy_o         out  1   high in every state except IDLE
// end_o          out  1   one-cycle pulse: tag available
// err_o          out  1   watchdog error, sticky (0 without macro)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; block counter 0; latched counts 0.
// - IDLE + start_i: latch counts. Counts > MAX_BLOCKS saturate to MAX_BLOCKS. Go to INIT_GO.
// - Reset mid-operation: IDLE on the next edge. No end_o or strobes that cycle.
// - INIT_GO: perm_start_o=1, rounds=PA_ROUNDS (1 cycle) -> INIT_RUN.
// - INIT_RUN: on perm_end_i, xor_key_o=1 (same cycle, registered decode). Next state:
//   - AD_WAIT if nb_ad>0,
//   - else DOM.
// - AD_WAIT: blk_ready_o=1. On handshake, cnt++ -> AD_GO.
// - AD_GO: perm_start_o, rounds=PB_ROUNDS -> AD_RUN.
// - AD_RUN: on perm_end_i: AD_WAIT if cnt<nb_ad, else cnt=0 -> DOM.
// - DOM: xor_dom_o=1 for 1 cycle. Next state:
//   - DATA_WAIT if nb_data>0,
//   - else FIN_KEY.
// - DATA_WAIT: blk_ready_o=1. On handshake, cnt++. Next state:
//   - FIN_KEY if cnt reaches nb_data (last block gets no pb),
//   - else DATA_GO.
// - DATA_GO: perm_start_o, rounds=PB_ROUNDS -> DATA_RUN.
// - DATA_RUN: perm_end_i -> DATA_WAIT.
// - FIN_KEY: xor_key_o=1 -> FIN_GO.
// - FIN_GO: perm_start_o, rounds=PA_ROUNDS -> FIN_RUN.
// - FIN_RUN: perm_end_i -> TAG.
// - TAG: xor_key_o=1 and end_o=1 in the same cycle -> IDLE.
// - Handshake and input rules:
//   - blk_ready_o is 0 outside the *_WAIT states.
//   - blk_valid_i is ignored when ready=0; no block is dropped.
//   - perm_end_i outside *_RUN states: ignored.
//   - start_i while busy_o=1: ignored; latched counts are unchanged.
//   - perm_end_i is never expected in the same cycle as perm_start_o. If it arrives then, it is ignored.
// - Latency: start_i -> perm_start_o is 1 cycle. perm_end_i -> next state is 1 cycle.
// CONFIGURATION
// - ASCON_SEQ_TIMEOUT_EN defined:
//   - Watchdog counts cycles in each *_RUN state.
//   - At TIMEOUT_CYC cycles without perm_end_i: err_o=1 (sticky), FSM -> IDLE, no end_o.
//   - err_o clears on reset_i or an accepted start_i.
// - ASCON_SEQ_TIMEOUT_EN undefined: no watchdog; err_o tied 0; *_RUN waits indefinitely.
// TESTING
// - T1 reset: reset_i=1 for 2 cycles mid-FIN_RUN -> IDLE next edge, all outputs 0, busy_o=0.
// - T2 nb_ad=1, nb_data=2, valid always 1, perm_end 3 cycles after each start:
//   - 4 perm_start pulses, rounds 12,6,6,12;
//   - 3 xor_key, 1 xor_dom, 3 block handshakes;
//   - exactly 1 end_o.
// - T3 nb_ad=0, nb_data=0:
//   - perm_start rounds 12,12;
//   - xor_dom pulses once between them;
//   - 0 block handshakes; end_o once.
// - T4 blk_valid_i held 0 for 10 cycles in AD_WAIT:
//   - blk_ready_o stays 1, FSM holds, no perm_start;
//   - resumes 1 cycle after valid rises.
// - T5 start_i pulsed during AD_RUN with nb_ad_i=5: ignored; original run completes with its counts.
// - T6 (macro on) perm_end_i withheld in INIT_RUN: err_o=1 after 64 cycles, FSM IDLE, end_o never pulses.

Source files
------------

// File: rtl/ascon_seq_ctrl.sv
// ASCON-128 encryption sequencer: init/AD/data/final permutation control.
// Optional watchdog on *_RUN states enabled by defining ASCON_SEQ_TIMEOUT_EN.
module ascon_seq_ctrl #(
   parameter int MAX_BLOCKS  = 16,
   parameter int PA_ROUNDS   = 12,
   parameter int PB_ROUNDS   = 6,
   parameter int TIMEOUT_CYC = 64,
   parameter int CW          = $clog2(MAX_BLOCKS + 1)
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic [CW-1:0] nb_ad_i,
   input  logic [CW-1:0] nb_data_i,
   input  logic          blk_valid_i,
   output logic          blk_ready_o,
   output logic          perm_start_o,
   output logic [3:0]    perm_rounds_o,
   input  logic          perm_end_i,
   output logic          xor_key_o,
   output logic          xor_dom_o,
   output logic [3:0]    phase_o,
   output logic          busy_o,
   output logic          end_o,
   output logic          err_o
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      INIT_GO   = 4'd1,
      INIT_RUN  = 4'd2,
      AD_WAIT   = 4'd3,
      AD_GO     = 4'd4,
      AD_RUN    = 4'd5,
      DOM       = 4'd6,
      DATA_WAIT = 4'd7,
      DATA_GO   = 4'd8,
      DATA_RUN  = 4'd9,
      FIN_KEY   = 4'd10,
      FIN_GO    = 4'd11,
      FIN_RUN   = 4'd12,
      TAG       = 4'd13
   } state_e;

   localparam logic [CW-1:0] MAX_C = CW'(MAX_BLOCKS);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] nb_ad_q;
   logic [CW-1:0] nb_data_q;
   logic [CW-1:0] cnt_d;

   assign cnt_d = cnt_q + ONE_C;

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] n);
      return (n > MAX_C) ? MAX_C : n;
   endfunction

`ifdef ASCON_SEQ_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

   logic [WW-1:0] wd_q;
   logic          err_q;
   logic          run_s;

   assign run_s = (state_q == INIT_RUN) || (state_q == AD_RUN) ||
                  (state_q == DATA_RUN) || (state_q == FIN_RUN);
   assign err_o = err_q;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         nb_ad_q   <= '0;
         nb_data_q <= '0;
`ifdef ASCON_SEQ_TIMEOUT_EN
         wd_q      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
`ifdef ASCON_SEQ_TIMEOUT_EN
         wd_q <= '0;
`endif
         unique case (state_q)
            IDLE: if (start_i) begin
               nb_ad_q   <= sat(nb_ad_i);
               nb_data_q <= sat(nb_data_i);
               cnt_q     <= '0;
`ifdef ASCON_SEQ_TIMEOUT_EN
               err_q     <= 1'b0;
`endif
               state_q   <= INIT_GO;
            end
            INIT_GO: state_q <= INIT_RUN;
            INIT_RUN: if (perm_end_i)
               state_q <= (nb_ad_q != '0) ? AD_WAIT : DOM;
            AD_WAIT: if (blk_valid_i) begin
               cnt_q   <= cnt_d;
               state_q <= AD_GO;
            end
            AD_GO: state_q <= AD_RUN;
            AD_RUN: if (perm_end_i) begin
               if (cnt_q < nb_ad_q) begin
                  state_q <= AD_WAIT;
               end else begin
                  cnt_q   <= '0;
                  state_q <= DOM;
               end
            end
            DOM: state_q <= (nb_data_q != '0) ? DATA_WAIT : FIN_KEY;
            // the last data block is absorbed into the final pa, no pb
            DATA_WAIT: if (blk_valid_i) begin
               cnt_q   <= cnt_d;
               state_q <= (cnt_d == nb_data_q) ? FIN_KEY : DATA_GO;
            end
            DATA_GO:  state_q <= DATA_RUN;
            DATA_RUN: if (perm_end_i) state_q <= DATA_WAIT;
            FIN_KEY:  state_q <= FIN_GO;
            FIN_GO:   state_q <= FIN_RUN;
            FIN_RUN:  if (perm_end_i) state_q <= TAG;
            TAG:      state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
`ifdef ASCON_SEQ_TIMEOUT_EN
         if (run_s && !perm_end_i) begin
            if (wd_q == WD_LAST) begin
               err_q   <= 1'b1;
               cnt_q   <= '0;
               state_q <= IDLE;
            end else begin
               wd_q <= wd_q + WW'(1);
            end
         end
`endif
      end
   end

   // strobes are suppressed while reset is asserted
   always_comb begin
      blk_ready_o   = 1'b0;
      perm_start_o  = 1'b0;
      perm_rounds_o = 4'd0;
      xor_key_o     = 1'b0;
      xor_dom_o     = 1'b0;
      end_o         = 1'b0;
      if (!reset_i) begin
         unique case (state_q)
            INIT_GO, FIN_GO: begin
               perm_start_o  = 1'b1;
               perm_rounds_o = 4'(PA_ROUNDS);
            end
            AD_GO, DATA_GO: begin
               perm_start_o  = 1'b1;
               perm_rounds_o = 4'(PB_ROUNDS);
            end
            INIT_RUN:           xor_key_o   = perm_end_i;
            AD_WAIT, DATA_WAIT: blk_ready_o = 1'b1;
            DOM:                xor_dom_o   = 1'b1;
            FIN_KEY:            xor_key_o   = 1'b1;
            TAG: begin
               xor_key_o = 1'b1;
               end_o     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign phase_o = state_q;
   assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Randomised bench for ascon_seq_ctrl, checked against an event-sequence model.
// Watchdog scenario is compiled in only with ASCON_SEQ_TIMEOUT_EN.
module tb_ascon_seq_ctrl;

   localparam int CW = 5;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic [CW-1:0] nb_ad_i;
   logic [CW-1:0] nb_data_i;
   logic          blk_valid_i;
   logic          blk_ready_o;
   logic          perm_start_o;
   logic [3:0]    perm_rounds_o;
   logic          perm_end_i;
   logic          xor_key_o;
   logic          xor_dom_o;
   logic [3:0]    phase_o;
   logic          busy_o;
   logic          end_o;
   logic          err_o;

   int errors = 0;
   int checks = 0;

   ascon_seq_ctrl dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .nb_ad_i      (nb_ad_i),
      .nb_data_i    (nb_data_i),
      .blk_valid_i  (blk_valid_i),
      .blk_ready_o  (blk_ready_o),
      .perm_start_o (perm_start_o),
      .perm_rounds_o(perm_rounds_o),
      .perm_end_i   (perm_end_i),
      .xor_key_o    (xor_key_o),
      .xor_dom_o    (xor_dom_o),
      .phase_o      (phase_o),
      .busy_o       (busy_o),
      .end_o        (end_o),
      .err_o        (err_o)
   );

   always #5 clock_i = ~clock_i;

   // event code: {end, handshake, dom, key, start, rounds}
   localparam logic [8:0] EV_S12 = 9'b0_0001_1100;
   localparam logic [8:0] EV_S6  = 9'b0_0001_0110;
   localparam logic [8:0] EV_K   = 9'b0_0010_0000;
   localparam logic [8:0] EV_D   = 9'b0_0100_0000;
   localparam logic [8:0] EV_H   = 9'b0_1000_0000;
   localparam logic [8:0] EV_T   = 9'b1_0010_0000;

   logic [8:0] exp_q[$];

   function automatic int satc(input int n);
      return (n > 16) ? 16 : n;
   endfunction

   function automatic void build_exp(input int nad, input int ndt);
      int a = satc(nad);
      int d = satc(ndt);
      exp_q.delete();
      exp_q.push_back(EV_S12);
      exp_q.push_back(EV_K);
      for (int i = 0; i < a; i++) begin
         exp_q.push_back(EV_H);
         exp_q.push_back(EV_S6);
      end
      exp_q.push_back(EV_D);
      for (int i = 0; i < d; i++) begin
         exp_q.push_back(EV_H);
         if (i < d - 1) exp_q.push_back(EV_S6);
      end
      exp_q.push_back(EV_K);
      exp_q.push_back(EV_S12);
      exp_q.push_back(EV_T);
   endfunction

   function automatic logic [20:0] all_outs();
      return {blk_ready_o, perm_start_o, perm_rounds_o, xor_key_o,
              xor_dom_o, end_o, busy_o, phase_o, err_o, 6'd0};
   endfunction

   task automatic do_reset();
      @(negedge clock_i);
      reset_i = 1'b1;
      start_i = 1'b0;
      blk_valid_i = 1'b0;
      perm_end_i = 1'b0;
      nb_ad_i = '0;
      nb_data_i = '0;
      @(negedge clock_i);
      @(negedge clock_i);
      reset_i = 1'b0;
   endtask

   // runs one operation; mode bits: stall first AD wait, poke start in AD_RUN,
   // reset during FIN_RUN
   task automatic run_op(input int nad, input int ndt, input int dmax,
                         input bit rnd, input bit stall, input bit poke,
                         input bit rst_fin, input string nm);
      logic [8:0] got[$];
      logic [8:0] ev;
      logic       hs;
      logic [3:0] ph0 = '0;
      int  pend = 0, ends = 0, cyc = 0, s12 = 0;
      int  st = stall ? 1 : 0, sn = 0, rs = 0;
      bit  done = 0, poked = 0, seen6 = 0, sbad = 0;
      bit  res_hs = 0, res_go = 0, lat_ok = 0;
      build_exp(nad, ndt);
      @(negedge clock_i);
      start_i = 1'b1;
      nb_ad_i = CW'(nad);
      nb_data_i = CW'(ndt);
      blk_valid_i = 1'b0;
      perm_end_i = 1'b0;
      while (!done && cyc < 3000) begin
         @(negedge clock_i);
         cyc++;
         start_i = 1'b0;
         nb_ad_i = CW'($urandom);
         nb_data_i = CW'($urandom);
         perm_end_i = (pend == 1);
         if (pend > 0) pend--;
         else if (rnd && $urandom_range(0, 7) == 0) perm_end_i = 1'b1;
         blk_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (st == 1 || st == 2) blk_valid_i = 1'b0;
         if (st == 3) blk_valid_i = 1'b1;
         if (poke && seen6 && !poked) begin
            start_i = 1'b1;
            nb_ad_i = 5'd5;
            poked = 1;
         end
         if (rs > 0) begin
            reset_i = (rs <= 2);
            perm_end_i = 1'b0;
            blk_valid_i = 1'b1;
         end
         #1;
         hs = blk_valid_i & blk_ready_o;
         ev = {end_o, hs, xor_dom_o, xor_key_o, perm_start_o, perm_rounds_o};
         if (cyc == 1) lat_ok = perm_start_o && perm_rounds_o == 4'd12;
         if (ev != '0) got.push_back(ev);
         if (end_o) ends++;
         if (perm_start_o) begin
            pend = $urandom_range(1, dmax);
            if (perm_rounds_o == 4'd6) seen6 = 1;
            if (perm_rounds_o == 4'd12) s12++;
         end
         unique case (st)
            1: if (blk_ready_o) begin
               st = 2;
               sn = 1;
               ph0 = phase_o;
            end
            2: begin
               if (!blk_ready_o || perm_start_o || phase_o !== ph0) sbad = 1;
               sn++;
               if (sn == 10) st = 3;
            end
            3: begin
               res_hs = hs;
               st = 4;
            end
            4: begin
               res_go = perm_start_o;
               st = 0;
            end
            default: ;
         endcase
         if (rs == 1) begin
            checks++;
            if ({perm_start_o, xor_key_o, xor_dom_o, end_o, blk_ready_o} !== 5'd0) begin
               errors++;
               $display("FAIL %s rst_strobes got=%b want=0", nm,
                        {perm_start_o, xor_key_o, xor_dom_o, end_o, blk_ready_o});
            end
         end
         if (rs == 2 || rs == 3) begin
            checks++;
            if (all_outs() !== 21'd0) begin
               errors++;
               $display("FAIL %s rst_outs step=%0d got=%h want=0", nm, rs, all_outs());
            end
         end
         if (rs > 0) begin
            if (rs == 3) done = 1;
            rs++;
         end
         if (rst_fin && rs == 0 && perm_start_o && s12 == 2) begin
            rs = 1;
            pend = 0;
         end
         if (!rst_fin && end_o) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout cycles=%0d want_end", nm, cyc);
      end
      checks++;
      if (!lat_ok) begin
         errors++;
         $display("FAIL %s start_latency got=0 want=perm_start(12) 1 cycle after start", nm);
      end
      if (rst_fin) begin
         checks++;
         if (ends != 0) begin
            errors++;
            $display("FAIL %s end_count got=%0d want=0", nm, ends);
         end
      end else begin
         bit ok = (got.size() == exp_q.size());
         int bad = -1;
         if (ok) foreach (got[i]) if (bad < 0 && got[i] !== exp_q[i]) bad = i;
         checks++;
         if (!ok || bad >= 0) begin
            errors++;
            if (!ok) $display("FAIL %s seq_len got=%0d want=%0d", nm, got.size(), exp_q.size());
            else $display("FAIL %s seq[%0d] got=%b want=%b", nm, bad, got[bad], exp_q[bad]);
         end
         checks++;
         if (ends != 1) begin
            errors++;
            $display("FAIL %s end_count got=%0d want=1", nm, ends);
         end
         @(negedge clock_i);
         blk_valid_i = 1'b0;
         perm_end_i = 1'b0;
         #1;
         checks++;
         if (busy_o !== 1'b0 || end_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s post_idle busy=%b end=%b err=%b want=000", nm,
                     busy_o, end_o, err_o);
         end
      end
      if (stall) begin
         checks++;
         if (sbad || st != 0) begin
            errors++;
            $display("FAIL %s stall_hold bad=%b st=%0d want bad=0 st=0", nm, sbad, st);
         end
         checks++;
         if (!res_hs || !res_go) begin
            errors++;
            $display("FAIL %s resume hs=%b go=%b want=11", nm, res_hs, res_go);
         end
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      do_reset();
      #1;
      checks++;
      if (all_outs() !== 21'd0) begin
         errors++;
         $display("FAIL reset_outs got=%h want=0", all_outs());
      end
   endtask

   task automatic test_basic();
      run_op(1, 2, 3, 0, 0, 0, 0, "t2_basic");
   endtask

   task automatic test_empty();
      run_op(0, 0, 3, 0, 0, 0, 0, "t3_empty");
   endtask

   task automatic test_stall();
      run_op(2, 1, 3, 0, 1, 0, 0, "t4_stall");
   endtask

   task automatic test_ignore_start();
      run_op(2, 1, 4, 0, 0, 1, 0, "t5_ignore");
   endtask

   task automatic test_saturate();
      run_op(31, 25, 2, 1, 0, 0, 0, "sat");
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++)
         run_op($urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(1, 5), 1, 0, 0, 0, $sformatf("rnd%0d", k));
   endtask

   task automatic test_reset_mid();
      run_op(1, 1, 3, 0, 0, 0, 1, "t1_rst_mid");
      reset_i = 1'b0;
      run_op(0, 1, 2, 1, 0, 0, 0, "t1_after");
   endtask

`ifdef ASCON_SEQ_TIMEOUT_EN
   task automatic test_watchdog();
      int run = 0, ends = 0, cyc = 0;
      bit fin = 0;
      @(negedge clock_i);
      start_i = 1'b1;
      nb_ad_i = '0;
      nb_data_i = '0;
      perm_end_i = 1'b0;
      while (!fin && cyc < 200) begin
         @(negedge clock_i);
         start_i = 1'b0;
         cyc++;
         #1;
         if (end_o) ends++;
         if (busy_o && !perm_start_o) run++;
         if (!busy_o) fin = 1;
      end
      checks++;
      if (run != 64 || err_o !== 1'b1 || ends != 0) begin
         errors++;
         $display("FAIL wdog run=%0d err=%b ends=%0d want 64 1 0", run, err_o, ends);
      end
      @(negedge clock_i);
      start_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      #1;
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL wdog_clear err=%b busy=%b want 0 1", err_o, busy_o);
      end
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_stall();
      test_ignore_start();
      test_saturate();
      test_random();
      test_reset_mid();
`ifdef ASCON_SEQ_TIMEOUT_EN
      test_watchdog();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
